// File: rtl/srec_pkg.sv
// srec_pkg: shared types and helpers for the S-record loader.
//   srec_state_t - parser state encoding
//   CHAR_*       - ASCII constants used by the parser
//   addr_len()   - address field length in bytes for a type digit, 0 if illegal
//   hex_val()    - {is_hex, nibble} for an ASCII character
package srec_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_TYPE,
    ST_COUNT,
    ST_ADDR,
    ST_DATA,
    ST_CSUM,
    ST_DONE
  } srec_state_t;

  localparam logic [7:0] CHAR_S  = 8'h53;
  localparam logic [7:0] CHAR_CR = 8'h0D;
  localparam logic [7:0] CHAR_LF = 8'h0A;

  function automatic logic [2:0] addr_len(input logic [7:0] type_digit);
    logic [2:0] len;
    case (type_digit)
      8'h30, 8'h31, 8'h35, 8'h39: len = 3'd2;
      8'h32, 8'h36, 8'h38:        len = 3'd3;
      8'h33, 8'h37:               len = 3'd4;
      default:                    len = 3'd0;
    endcase
    return len;
  endfunction

  function automatic logic [4:0] hex_val(input logic [7:0] ch);
    logic [4:0] r;
    if (ch >= 8'h30 && ch <= 8'h39)
      r = {1'b1, ch[3:0]};
    else if ((ch >= 8'h41 && ch <= 8'h46) || (ch >= 8'h61 && ch <= 8'h66))
      r = {1'b1, ch[3:0] + 4'd9};  // 'A'/'a' have low nibble 1 -> 10
    else
      r = 5'b0;
    return r;
  endfunction

endpackage

// File: rtl/srec_hex_byte.sv
// srec_hex_byte: assembles two ASCII hex digits (high nibble first) into a byte.
//   clr        - drop any half-received byte
//   nib_valid  - char_in is a field character accepted this cycle
//   char_in    - ASCII character
//   byte_valid - low nibble accepted this cycle; byte_out is complete
//   byte_out   - assembled byte
//   err        - char_in is not a hex digit (half byte is discarded)
module srec_hex_byte
  import srec_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic       clr,
  input  logic       nib_valid,
  input  logic [7:0] char_in,
  output logic       byte_valid,
  output logic [7:0] byte_out,
  output logic       err
);

  logic       have_hi_q, have_hi_d;
  logic [3:0] hi_q, hi_d;
  logic [4:0] hv;

  always_comb begin
    hv         = hex_val(char_in);
    have_hi_d  = have_hi_q;
    hi_d       = hi_q;
    byte_valid = 1'b0;
    err        = 1'b0;
    byte_out   = {hi_q, hv[3:0]};
    if (clr) begin
      have_hi_d = 1'b0;
    end else if (nib_valid) begin
      if (!hv[4]) begin
        err       = 1'b1;
        have_hi_d = 1'b0;
      end else if (have_hi_q) begin
        byte_valid = 1'b1;
        have_hi_d  = 1'b0;
      end else begin
        have_hi_d = 1'b1;
        hi_d      = hv[3:0];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      have_hi_q <= 1'b0;
      hi_q      <= 4'h0;
    end else begin
      have_hi_q <= have_hi_d;
      hi_q      <= hi_d;
    end
  end

endmodule

// File: rtl/srec_loader.sv
// srec_loader: parses a Motorola S-record ASCII stream, checks record
// checksums and issues byte writes for S1/S2/S3 data.
//   rx_data/rx_valid/rx_ready - byte stream from the UART receiver
//   wr_addr/wr_data/wr_valid/wr_ready - byte write port to memory
//   done, entry_addr          - terminating record accepted, its address
//   err_char/err_csum/err_len - sticky error flags
//   rec_count                 - saturating count of good-checksum records
//
// state    | meaning
// IDLE     | waiting for 'S', everything else dropped
// TYPE     | expecting the record type digit
// COUNT    | receiving the byte count
// ADDR     | receiving address bytes, MSB first
// DATA     | receiving data bytes (written for S1/S2/S3)
// CSUM     | receiving and comparing the checksum
// DONE     | terminating record accepted, input absorbed until reset
module srec_loader
  import srec_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  output logic                  rx_ready,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [7:0]            wr_data,
  output logic                  wr_valid,
  input  logic                  wr_ready,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] entry_addr,
  output logic                  err_char,
  output logic                  err_csum,
  output logic                  err_len,
  output logic [CNT_WIDTH-1:0]  rec_count
);

  srec_state_t           state_q, state_d;
  logic [3:0]            type_q, type_d;
  logic [2:0]            alen_q, alen_d;
  logic [2:0]            abytes_q, abytes_d;
  logic [7:0]            remain_q, remain_d;
  logic [7:0]            sum_q, sum_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  wr_valid_q, wr_valid_d;
  logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [7:0]            wr_data_q, wr_data_d;
  logic                  done_q, done_d;
  logic [ADDR_WIDTH-1:0] entry_q, entry_d;
  logic                  err_char_q, err_char_d;
  logic                  err_csum_q, err_csum_d;
  logic                  err_len_q, err_len_d;
  logic [CNT_WIDTH-1:0]  rec_count_q, rec_count_d;

  logic       rx_fire, field_st, hb_valid, hb_err;
  logic [7:0] hb_byte;
  logic [2:0] alen;

  assign rx_ready = ~wr_valid_q;
  assign rx_fire  = rx_valid & ~wr_valid_q;
  assign field_st = state_q inside {ST_COUNT, ST_ADDR, ST_DATA, ST_CSUM};
  assign alen     = addr_len(rx_data);

  srec_hex_byte u_hex (
    .clk       (clk),
    .reset_n   (reset_n),
    .clr       (~field_st),
    .nib_valid (rx_fire & field_st),
    .char_in   (rx_data),
    .byte_valid(hb_valid),
    .byte_out  (hb_byte),
    .err       (hb_err)
  );

  always_comb begin
    state_d     = state_q;
    type_d      = type_q;
    alen_d      = alen_q;
    abytes_d    = abytes_q;
    remain_d    = remain_q;
    sum_d       = sum_q;
    addr_d      = addr_q;
    wr_valid_d  = wr_valid_q;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    done_d      = done_q;
    entry_d     = entry_q;
    err_char_d  = err_char_q;
    err_csum_d  = err_csum_q;
    err_len_d   = err_len_q;
    rec_count_d = rec_count_q;

    if (wr_valid_q && wr_ready) wr_valid_d = 1'b0;

    case (state_q)
      ST_IDLE: if (rx_fire && rx_data == CHAR_S) state_d = ST_TYPE;
      ST_TYPE: if (rx_fire) begin
        if (!(rx_data inside {[8'h30:8'h39]})) begin
          err_char_d = 1'b1;
          state_d    = ST_IDLE;
        end else if (alen == 3'd0) begin
          err_len_d = 1'b1;
          state_d   = ST_IDLE;
        end else begin
          type_d  = rx_data[3:0];
          alen_d  = alen;
          state_d = ST_COUNT;
        end
      end
      ST_COUNT: if (hb_valid) begin
        if (hb_byte < 8'(alen_q) + 8'd1) begin
          err_len_d = 1'b1;
          state_d   = ST_IDLE;
        end else begin
          remain_d = hb_byte - 8'(alen_q) - 8'd1;
          sum_d    = hb_byte;
          abytes_d = alen_q;
          addr_d   = '0;
          state_d  = ST_ADDR;
        end
      end
      ST_ADDR: if (hb_valid) begin
        addr_d   = {addr_q[ADDR_WIDTH-9:0], hb_byte};
        sum_d    = sum_q + hb_byte;
        abytes_d = abytes_q - 3'd1;
        if (abytes_q == 3'd1) state_d = (remain_q != 8'd0) ? ST_DATA : ST_CSUM;
      end
      ST_DATA: if (hb_valid) begin
        sum_d    = sum_q + hb_byte;
        remain_d = remain_q - 8'd1;
        // addr_q doubles as the write pointer; it only advances on writes
        if (type_q inside {4'd1, 4'd2, 4'd3}) begin
          wr_valid_d = 1'b1;
          wr_addr_d  = addr_q;
          wr_data_d  = hb_byte;
          addr_d     = addr_q + ADDR_WIDTH'(1);
        end
        if (remain_q == 8'd1) state_d = ST_CSUM;
      end
      ST_CSUM: if (hb_valid) begin
        if (hb_byte == ~sum_q) begin
          if (rec_count_q != {CNT_WIDTH{1'b1}}) rec_count_d = rec_count_q + CNT_WIDTH'(1);
          if (type_q inside {4'd7, 4'd8, 4'd9}) begin
            entry_d = addr_q;
            done_d  = 1'b1;
            state_d = ST_DONE;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          err_csum_d = 1'b1;
          state_d    = ST_IDLE;
        end
      end
      ST_DONE: ;
      default: state_d = ST_IDLE;
    endcase

    if (hb_err) begin
      err_char_d = 1'b1;
      state_d    = ST_IDLE;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      type_q      <= 4'h0;
      alen_q      <= 3'd0;
      abytes_q    <= 3'd0;
      remain_q    <= 8'd0;
      sum_q       <= 8'd0;
      addr_q      <= '0;
      wr_valid_q  <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= 8'd0;
      done_q      <= 1'b0;
      entry_q     <= '0;
      err_char_q  <= 1'b0;
      err_csum_q  <= 1'b0;
      err_len_q   <= 1'b0;
      rec_count_q <= '0;
    end else begin
      state_q     <= state_d;
      type_q      <= type_d;
      alen_q      <= alen_d;
      abytes_q    <= abytes_d;
      remain_q    <= remain_d;
      sum_q       <= sum_d;
      addr_q      <= addr_d;
      wr_valid_q  <= wr_valid_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      done_q      <= done_d;
      entry_q     <= entry_d;
      err_char_q  <= err_char_d;
      err_csum_q  <= err_csum_d;
      err_len_q   <= err_len_d;
      rec_count_q <= rec_count_d;
    end
  end

  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;
  assign wr_valid   = wr_valid_q;
  assign done       = done_q;
  assign entry_addr = entry_q;
  assign err_char   = err_char_q;
  assign err_csum   = err_csum_q;
  assign err_len    = err_len_q;
  assign rec_count  = rec_count_q;

endmodule

// File: tb/tb_srec_loader.sv
// Bench for srec_loader: directed records plus randomized records, checked
// against a string-level reference parser of the S-record rules.
module tb_srec_loader;

  logic        clk;
  logic        reset_n;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic [31:0] wr_addr;
  logic [7:0]  wr_data;
  logic        wr_valid;
  logic        wr_ready;
  logic        done;
  logic [31:0] entry_addr;
  logic        err_char;
  logic        err_csum;
  logic        err_len;
  logic [15:0] rec_count;

  srec_loader #(.ADDR_WIDTH(32), .CNT_WIDTH(16)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .done      (done),
    .entry_addr(entry_addr),
    .err_char  (err_char),
    .err_csum  (err_csum),
    .err_len   (err_len),
    .rec_count (rec_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // reference model state
  logic [39:0] exp_q[$];
  logic [39:0] obs_q[$];
  bit          m_char, m_csum, m_len, m_done;
  logic [31:0] m_entry;
  int          m_cnt;

  bit rand_wr    = 1'b0;
  int stall_left = 0;
  int tlist[7]   = '{0, 1, 2, 3, 5, 6, 3};

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int hexnib(input byte c);
    if (c >= 8'h30 && c <= 8'h39) return int'(c) - 48;
    if (c >= 8'h41 && c <= 8'h46) return int'(c) - 55;
    if (c >= 8'h61 && c <= 8'h66) return int'(c) - 87;
    return -1;
  endfunction

  function automatic int alen_of(input int t);
    if (t == 2 || t == 6 || t == 8) return 3;
    if (t == 3 || t == 7) return 4;
    return 2;
  endfunction

  // Parses one record string ("S" first) and updates the expectations.
  task automatic model_rec(input string s);
    int t, alen, cnt, sum, hi, lo, b;
    logic [31:0] a;
    if (m_done || s.len() < 2) return;
    if (!(s[1] >= 8'h30 && s[1] <= 8'h39)) begin m_char = 1; return; end
    t = int'(s[1]) - 48;
    if (t == 4) begin m_len = 1; return; end
    alen = alen_of(t);
    sum = 0; a = 0; cnt = 0;
    for (int k = 0; k < 300; k++) begin
      if (2 + 2*k >= s.len()) return;
      hi = hexnib(s[2+2*k]);
      if (hi < 0) begin m_char = 1; return; end
      if (3 + 2*k >= s.len()) return;
      lo = hexnib(s[3+2*k]);
      if (lo < 0) begin m_char = 1; return; end
      b = hi * 16 + lo;
      if (k == 0) begin
        cnt = b;
        if (cnt < alen + 1) begin m_len = 1; return; end
      end else if (k <= alen) begin
        a = (a << 8) | 32'(b);
      end else if (k < cnt) begin
        if (t >= 1 && t <= 3) exp_q.push_back({a + 32'(k - alen - 1), 8'(b)});
      end else begin
        if (((sum + b) & 255) == 255) begin
          if (m_cnt < 65535) m_cnt++;
          if (t >= 7) begin m_done = 1; m_entry = a; end
        end else begin
          m_csum = 1;
        end
        return;
      end
      sum += b;
    end
  endtask

  function automatic string mk_rec(input int t, input logic [31:0] a, input int n,
                                   input bit badc, input bit lower);
    int alen, sum, b;
    string body;
    alen = alen_of(t);
    sum  = alen + n + 1;
    body = $sformatf("%02X", alen + n + 1);
    for (int i = alen - 1; i >= 0; i--) begin
      b = int'((a >> (8*i)) & 32'hFF);
      body = {body, $sformatf("%02X", b)};
      sum += b;
    end
    for (int i = 0; i < n; i++) begin
      b = int'($urandom_range(0, 255));
      body = {body, $sformatf("%02X", b)};
      sum += b;
    end
    b = (~sum) & 255;
    if (badc) b = b ^ 1;
    body = {body, $sformatf("%02X", b)};
    if (lower) body = body.tolower();
    return {"S", $sformatf("%0d", t), body};
  endfunction

  // One clock: drive at negedge, sample just after it.
  task automatic step(input bit offer, input logic [7:0] b, output bit took);
    @(negedge clk);
    rx_valid = offer;
    rx_data  = b;
    if (stall_left > 0 && wr_valid === 1'b1) begin
      wr_ready = 1'b0;
      stall_left--;
      check("stall_hold", {16'h0, wr_addr, wr_data, 7'b0, rx_ready}, {16'h0, 32'h0, 8'hAA, 8'h00});
    end else begin
      wr_ready = rand_wr ? ($urandom_range(0, 2) != 0) : 1'b1;
    end
    #1;
    took = offer && (rx_ready === 1'b1);
    if (wr_valid === 1'b1 && wr_ready === 1'b1) obs_q.push_back({wr_addr, wr_data});
  endtask

  task automatic send_byte(input logic [7:0] b);
    bit took;
    took = 1'b0;
    for (int i = 0; i < 100 && !took; i++) step(1'b1, b, took);
    check("rx_accept", 64'(took), 64'd1);
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(8'(s[i]));
  endtask

  task automatic drain();
    bit took;
    for (int i = 0; i < 200; i++) begin
      step(1'b0, 8'h00, took);
      if (wr_valid === 1'b0) break;
    end
  endtask

  task automatic check_state(input string tag);
    check({tag, ":wr_count"}, 64'(obs_q.size()), 64'(exp_q.size()));
    while (obs_q.size() > 0 && exp_q.size() > 0)
      check({tag, ":write"}, 64'(obs_q.pop_front()), 64'(exp_q.pop_front()));
    obs_q.delete();
    exp_q.delete();
    check({tag, ":flags"}, 64'({done, err_char, err_csum, err_len}),
          64'({m_done, m_char, m_csum, m_len}));
    check({tag, ":rec_count"}, 64'(rec_count), 64'(m_cnt));
    check({tag, ":entry"}, 64'(entry_addr), 64'(m_entry));
    check({tag, ":idle_io"}, 64'({wr_valid, rx_ready}), 64'(2'b01));
  endtask

  task automatic rec(input string s, input string tag);
    model_rec(s);
    send_str(s);
    drain();
    check_state(tag);
  endtask

  task automatic model_reset();
    m_char = 0; m_csum = 0; m_len = 0; m_done = 0; m_entry = 0; m_cnt = 0;
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    reset_n  = 1'b0;
    rx_valid = 1'b0;
    #1;
    check("reset_ctl", 64'({rx_ready, wr_valid, done, err_char, err_csum, err_len}), 64'(6'b100000));
    check("reset_val", 64'({wr_addr, wr_data, rec_count}), 64'd0);
    check("reset_entry", 64'(entry_addr), 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    model_reset();
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t, n;
    logic [31:0] a;
    string s;

    reset_n  = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    wr_ready = 1'b1;
    model_reset();
    #1;
    check("por_ctl", 64'({rx_ready, wr_valid, done, err_char, err_csum, err_len}), 64'(6'b100000));
    check("por_val", 64'({wr_addr, wr_data, rec_count}), 64'd0);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;

    rec("S1070000AABBCCDDEA\r\n", "s1_basic");

    stall_left = 20;
    rec("S1070000AABBCCDDEA", "s1_stall");
    check("stall_used", 64'(stall_left), 64'd0);

    rec(mk_rec(3, 32'hFFFF_FFFE, 3, 0, 0), "s3_wrap");
    rec(mk_rec(1, 32'h0000_FFFE, 3, 0, 1), "s1_nowrap16");
    rec("S1030000FC", "s1_nodata");

    rec("S10G11", "err_char");
    rec("S4030000FC", "err_s4");
    rec("S1020000FD", "err_shortcnt");
    rec(mk_rec(1, 32'h0000_1234, 2, 0, 0), "s1_after_err");

    rand_wr = 1'b1;
    for (int r = 0; r < 30; r++) begin
      t = tlist[$urandom_range(0, 6)];
      a = $urandom;
      if (t == 0 || t == 1 || t == 5) a = a & 32'h0000_FFFF;
      else if (t == 2 || t == 6) a = a & 32'h00FF_FFFF;
      n = int'($urandom_range(0, 5));
      s = mk_rec(t, a, n, $urandom_range(0, 5) == 0, $urandom_range(0, 1) == 1);
      if ($urandom_range(0, 9) == 0) s.putc(int'($urandom_range(2, s.len() - 1)), "G");
      if ($urandom_range(0, 2) == 0) send_str("\r\n");
      rec(s, "random");
    end
    rand_wr = 1'b0;

    rec("S1070000AABBCCDDEB", "bad_csum");

    send_str("S3098000");
    pulse_reset();
    rec(mk_rec(3, 32'h2000_0100, 4, 0, 0), "after_reset");

    rec("S306800000105A0F", "s3_single");
    rec("S705800000007A", "s7_done");
    rec("S1070000AABBCCDDEA", "frozen");

    pulse_reset();
    rec("S1070000AABBCCDDEB", "bad_csum2");
    rec("S9030000FC", "s9_done");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/srec_loader.md
Name: srec_loader

Overview:
- Boot-path stage directly downstream of the SoC UART receiver.
- Consumes the received ASCII byte stream, parses Motorola S-records (S0–S9), verifies per-record checksums and issues byte writes to the memory write port.
- Reports the entry address from the terminating S7/S8/S9 record, plus sticky error flags, to the boot controller/CPU reset release.

Parameters:
ADDR_WIDTH, 32, width of wr_addr and entry_addr; S1/S2 addresses are zero-extended to this width.
CNT_WIDTH, 16, width of rec_count; saturates at all-ones.

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
rx_data  in  8  received byte from UART RX
rx_valid  in  1  rx_data valid
rx_ready  out  1  loader accepts rx_data this cycle
wr_addr  out  ADDR_WIDTH  byte write address
wr_data  out  8  byte write data
wr_valid  out  1  write request
wr_ready  in  1  memory accepts write
done  out  1  terminating record accepted with valid checksum; sticky
entry_addr  out  ADDR_WIDTH  address field of the terminating record
err_char  out  1  illegal character inside a record; sticky
err_csum  out  1  checksum mismatch; sticky
err_len  out  1  count field < address bytes + 1, or record type S4; sticky
rec_count  out  CNT_WIDTH  number of records with a good checksum (all types)

Behaviour:
- Reset (async, reset_n=0): all outputs 0 except rx_ready=1; state IDLE.
- Handshakes:
  - A byte transfers when rx_valid&rx_ready.
  - A write transfers when wr_valid&wr_ready.
  - wr_addr/wr_data/wr_valid are held stable until accepted.
- Flow control: rx_ready=0 while wr_valid=1; otherwise rx_ready=1 in every state, including DONE.
- Hex digits: '0'-'9', 'A'-'F', 'a'-'f'. Each field byte is two digits, high nibble first.
- States: IDLE, TYPE, COUNT, ADDR, DATA, CSUM, DONE.
  - IDLE: 'S' -> TYPE; every other byte (CR, LF, garbage) is discarded silently.
  - TYPE: digit sets the address length: 0/1/5/9 -> 2 bytes; 2/8 -> 3 bytes; 3/7 -> 4 bytes; 6 -> 3 bytes. '4' -> err_len, go to IDLE. Non-digit -> err_char, go to IDLE.
  - COUNT: latch count byte. If count < addrlen+1 -> err_len, go to IDLE. Else go to ADDR. Running sum starts at count.
  - ADDR: shift in addrlen bytes MSB first; add each to the sum. Then go to DATA when remaining = count-addrlen-1 > 0, else CSUM.
  - DATA: for each completed byte of S1/S2/S3, assert wr_valid the cycle after the low nibble is accepted, with wr_addr = record address + byte index. The index increments in full ADDR_WIDTH arithmetic, wrapping modulo 2^ADDR_WIDTH; there is no 16-bit wrap for S1. S0/S5/S6 data is summed only, never written.
  - CSUM: compare the received byte to ~(sum[7:0]).
    - Match: rec_count+1. For S7/S8/S9, latch entry_addr, set done, go to DONE. Otherwise go to IDLE.
    - Mismatch: set err_csum, go to IDLE.
- Data writes are not rolled back on a later checksum error; software treats any err_* as a failed load.
- Any non-hex byte in COUNT/ADDR/DATA/CSUM, including 'S', CR and LF, sets err_char and returns to IDLE. A pending write still completes.
- A half-received byte (high nibble only) is discarded on any error.
- DONE: absorbs all further bytes; outputs are frozen until reset.
- Reset asserted mid-record or mid-write drops wr_valid immediately. There is no partial-state recovery.
- rec_count saturates at all-ones.

Decomposition:
- Package srec_pkg contains:
  - state enum srec_state_t;
  - ASCII constants (CHAR_S, CHAR_CR, CHAR_LF);
  - function addr_len(type_digit) returning 2/3/4, or 0 for illegal;
  - function hex_val(byte) returning {is_hex, nibble}.
- One sub-module, srec_hex_byte: accumulates two nibbles and outputs byte_valid, byte and err. It is reused by all field states.

Test Plan:
- "S1070000AABBCCDDEA\r\n" with wr_ready=1 -> writes (0x0,AA), (0x1,BB), (0x2,CC), (0x3,DD); rec_count=1; no errors.
- "S306800000105A0F" then "S70580000000 7A" sent without the space -> write (0x80000010,5A); done=1; entry_addr=0x80000000; rec_count=2.
- "S1070000AABBCCDDEB" -> the four writes still occur; err_csum=1; rec_count=0. A following "S9030000FC" -> done=1, entry_addr=0.
- wr_ready held 0 for 20 cycles during the first data byte -> wr_valid and wr_addr=0 stable; rx_ready=0 throughout; no bytes lost once wr_ready=1.
- "S10G..." -> err_char=1, parser returns to IDLE. "S4..." -> err_len=1. "S102..." (count 2 < 3) -> err_len=1. A valid S1 afterwards still loads.
- Assert reset_n=0 for 1 cycle after an address byte of an S3 record -> all outputs 0, rx_ready=1. A full valid record afterwards loads correctly.
